frequency_generator: RTL and testbench
======================================

Name: frequency_generator

Overview:
Test-signal source, the transmit-side counterpart of the frequency counter. It takes a two-digit BCD frequency setting (tens, units) and emits a square wave on `signal`. The wave has exactly that many rising edges in every measurement window of UPDATE_PERIOD+1 clocks. Its output drives the counter's `signal` input for closed-loop self-test, with both blocks sharing the same UPDATE_PERIOD.

Parameters:
UPDATE_PERIOD, 1200 - 1, window length minus one; window P = UPDATE_PERIOD+1 clocks; P must exceed 198.
BITS, 12, width of the window counter; 2^BITS must be at least P.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
load  input  1  request to accept a new setting; sampled only when busy=0
ten_count  input  4  BCD tens digit of the requested edges per window
unit_count  input  4  BCD units digit of the requested edges per window
signal  output  1  generated square wave, registered
busy  output  1  BCD-to-binary conversion in progress; load is ignored while high
bcd_error  output  1  one-cycle pulse when a load carries a digit > 9
period_start  output  1  high on the first cycle of each generation window

Behaviour:
- Reset (synchronous, active-high, wins over all other activity, including mid-conversion and mid-window):
  - all outputs return to 0;
  - generator state = IDLE; converter state = CIDLE;
  - freq, pending, pending_valid, acc and clk_counter are all cleared to 0.
- Two concurrent FSMs: the converter (CIDLE/CONV) and the generator (IDLE/RUN). Generation continues while a conversion is running.
- Load acceptance, in the cycle load=1 with busy=0:
  - Either digit > 9: bcd_error=1 on the next cycle for one cycle; the setting is discarded; the generator is unaffected.
  - Otherwise: capture both digits, clear the binary accumulator, set busy=1 on the next cycle, go to CONV.
- CONV:
  - Each cycle with tens_reg != 0: bin += 10, tens_reg -= 1.
  - When tens_reg == 0: bin += units; pending <= bin; pending_valid <= 1; busy <= 0; go to CIDLE.
  - busy stays high for ten_count+1 cycles (0/x → 1 cycle, 9/x → 10 cycles).
  - bin is 7 bits (maximum 99).
- pending_valid set while one is already pending: the new value overwrites the old one. Only the last accepted setting takes effect.
- Generator IDLE:
  - signal is held at 0.
  - When pending_valid=1: freq <= pending, clear pending_valid, clk_counter <= 0, acc <= 0, go to RUN.
- Generator RUN, boundary cycle (clk_counter == UPDATE_PERIOD):
  - clk_counter <= 0, acc <= 0, signal <= 0.
  - If pending_valid: freq <= pending and pending_valid cleared.
  - A new setting therefore takes effect only at a window boundary; a window in progress always completes with the old freq.
- Generator RUN, other cycles:
  - clk_counter += 1.
  - s = acc + 2*freq.
  - If s >= P: acc <= s - P and signal toggles.
  - Otherwise: acc <= s.
- Arithmetic widths:
  - acc is BITS+1 bits so s cannot overflow.
  - 2*freq is at most 198 < P, so at most one toggle per clock.
- Edge-count guarantee:
  - A window has P-1 accumulate cycles, giving floor(2N(P-1)/P) = 2N-1 toggles for N >= 1.
  - This yields exactly N rising edges per window; signal is high before the boundary and forced low at it.
  - N=0 keeps signal at 0 throughout.
- period_start is registered: it is 1 exactly in cycles where the generator is in RUN and clk_counter == 0, including the first cycle after leaving IDLE.
- Once RUN is entered, the generator never returns to IDLE except through reset.

Test Plan:
1. Reset, then idle for 3000 cycles → signal, busy, bcd_error and period_start remain 0.
2. load 4/2 from reset → busy high for exactly 5 cycles, then RUN; period_start pulses every 1200 cycles; each of 3 windows contains 42 rising edges; signal=0 at each boundary.
3. load 9/9 → busy high for 10 cycles, then 99 edges per window. Then load 0/0 → after the next boundary, 0 edges and signal stuck at 0.
4. While running 42, load ten=0xA, unit=3 → bcd_error pulses for 1 cycle, busy stays 0, windows keep 42 edges.
5. While running 42, load 1/5 at clock 300 of a window → that window still counts 42 edges, subsequent windows count 15. A second load 2/0 before the boundary → the next window counts 20, not 15.
6. Assert reset mid-window during RUN, and again mid-CONV → the next cycle shows all outputs 0, the generator in IDLE, and no pending setting; a subsequent load 0/7 produces 7 edges per window.

Source files
------------

// File: rtl/frequency_generator.sv
// Square-wave test source: emits N rising edges per window of UPDATE_PERIOD+1 clocks,
// where N is a two-digit BCD setting converted to binary by a small iterative converter.
module frequency_generator #(
  parameter int UPDATE_PERIOD = 1200 - 1,
  parameter int BITS          = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ten_count,
  input  logic [3:0] unit_count,
  output logic       signal,
  output logic       busy,
  output logic       bcd_error,
  output logic       period_start
);

  typedef enum logic { CIDLE = 1'b0, CONV = 1'b1 } conv_state_t;
  typedef enum logic { IDLE  = 1'b0, RUN  = 1'b1 } gen_state_t;

  localparam logic [BITS:0]   PERIOD = (BITS+1)'(UPDATE_PERIOD + 1);
  localparam logic [BITS-1:0] LAST   = BITS'(UPDATE_PERIOD);

  conv_state_t     conv_state_q;
  gen_state_t      gen_state_q;
  logic [3:0]      tens_q;
  logic [3:0]      units_q;
  logic [6:0]      bin_q;
  logic [6:0]      pending_q;
  logic            pending_valid_q;
  logic [6:0]      freq_q;
  logic [BITS:0]   acc_q;
  logic [BITS-1:0] clk_counter_q;
  logic            signal_q;
  logic            busy_q;
  logic            bcd_error_q;
  logic            period_start_q;

  logic [BITS:0]   step_sum_d;
  logic            wrap_d;
  logic [BITS:0]   acc_step_d;
  logic            bad_digit_d;
  logic [6:0]      conv_result_d;

  // Phase accumulator: adds 2*freq per clock, toggling signal each time it passes PERIOD.
  always_comb begin
    step_sum_d    = acc_q + {{(BITS-7){1'b0}}, freq_q, 1'b0};
    wrap_d        = (step_sum_d >= PERIOD);
    acc_step_d    = wrap_d ? (step_sum_d - PERIOD) : step_sum_d;
    bad_digit_d   = (ten_count > 4'd9) || (unit_count > 4'd9);
    conv_result_d = bin_q + {3'b000, units_q};
  end

  // Handshake: a setting is taken on any clock where load=1 and busy=0; while busy=1 load is
  // ignored. The generator logic sits first so a conversion finishing in the same cycle the
  // generator consumes pending keeps its fresh value valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      conv_state_q    <= CIDLE;
      gen_state_q     <= IDLE;
      tens_q          <= '0;
      units_q         <= '0;
      bin_q           <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      freq_q          <= '0;
      acc_q           <= '0;
      clk_counter_q   <= '0;
      signal_q        <= 1'b0;
      busy_q          <= 1'b0;
      bcd_error_q     <= 1'b0;
      period_start_q  <= 1'b0;
    end else begin
      bcd_error_q    <= 1'b0;
      period_start_q <= 1'b0;

      case (gen_state_q)
        IDLE: begin
          signal_q <= 1'b0;
          if (pending_valid_q) begin
            freq_q          <= pending_q;
            pending_valid_q <= 1'b0;
            clk_counter_q   <= '0;
            acc_q           <= '0;
            period_start_q  <= 1'b1;
            gen_state_q     <= RUN;
          end
        end
        RUN: begin
          if (clk_counter_q == LAST) begin
            clk_counter_q  <= '0;
            acc_q          <= '0;
            signal_q       <= 1'b0;
            period_start_q <= 1'b1;
            if (pending_valid_q) begin
              freq_q          <= pending_q;
              pending_valid_q <= 1'b0;
            end
          end else begin
            clk_counter_q <= clk_counter_q + 1'b1;
            acc_q         <= acc_step_d;
            if (wrap_d) signal_q <= ~signal_q;
          end
        end
        default: gen_state_q <= IDLE;
      endcase

      case (conv_state_q)
        CIDLE: begin
          if (load) begin
            if (bad_digit_d) begin
              bcd_error_q <= 1'b1;
            end else begin
              tens_q       <= ten_count;
              units_q      <= unit_count;
              bin_q        <= '0;
              busy_q       <= 1'b1;
              conv_state_q <= CONV;
            end
          end
        end
        CONV: begin
          if (tens_q != 4'd0) begin
            bin_q  <= bin_q + 7'd10;
            tens_q <= tens_q - 1'b1;
          end else begin
            pending_q       <= conv_result_d;
            pending_valid_q <= 1'b1;
            busy_q          <= 1'b0;
            conv_state_q    <= CIDLE;
          end
        end
        default: conv_state_q <= CIDLE;
      endcase
    end
  end

  assign signal       = signal_q;
  assign busy         = busy_q;
  assign bcd_error    = bcd_error_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_frequency_generator.sv
// Bench for frequency_generator: directed loads, expected edge counts and pulse lengths are
// queued by the stimulus and compared by a monitor as windows and pulses complete.
module tb_frequency_generator;

  localparam int P = 1200;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] ten_count;
  logic [3:0] unit_count;
  logic       signal;
  logic       busy;
  logic       bcd_error;
  logic       period_start;

  int checks = 0;
  int errors = 0;

  logic [7:0] win_exp_q[$];
  logic [7:0] busy_exp_q[$];
  logic [7:0] err_exp_q[$];

  frequency_generator #(.UPDATE_PERIOD(P - 1), .BITS(12)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .ten_count    (ten_count),
    .unit_count   (unit_count),
    .signal       (signal),
    .busy         (busy),
    .bcd_error    (bcd_error),
    .period_start (period_start)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   rises = 0;
  int   win_len = 0;
  int   busy_len = 0;
  int   err_len = 0;
  bit   in_win = 1'b0;
  logic prev_sig = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      in_win   = 1'b0;
      rises    = 0;
      win_len  = 0;
      busy_len = 0;
      err_len  = 0;
      prev_sig = 1'b0;
    end else begin
      if (period_start) begin
        if (in_win && win_exp_q.size() > 0) begin
          check("window_edges", rises, int'(win_exp_q.pop_front()));
          check("window_len", win_len, P);
          check("boundary_low", int'(signal), 0);
        end
        in_win  = 1'b1;
        rises   = 0;
        win_len = 0;
      end
      if (in_win) begin
        win_len++;
        if (signal && !prev_sig) rises++;
      end
      prev_sig = signal;

      if (busy) begin
        busy_len++;
      end else if (busy_len != 0) begin
        if (busy_exp_q.size() == 0) check("unexpected_busy", busy_len, 0);
        else check("busy_len", busy_len, int'(busy_exp_q.pop_front()));
        busy_len = 0;
      end

      if (bcd_error) begin
        err_len++;
      end else if (err_len != 0) begin
        if (err_exp_q.size() == 0) check("unexpected_bcd_error", err_len, 0);
        else check("bcd_error_len", err_len, int'(err_exp_q.pop_front()));
        err_len = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [3:0] t, input logic [3:0] u);
    @(negedge clk);
    ten_count  = t;
    unit_count = u;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  // Returns one posedge after a period_start, i.e. inside the window that just began.
  task automatic sync_window();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 1500);
    if (!period_start) check("sync_timeout", n, 0);
    @(posedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (win_exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check(name, win_exp_q.size(), 0);
    win_exp_q.delete();
  endtask

  task automatic quiet(input string name, input int cycles);
    int cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (signal || busy || bcd_error || period_start) cnt++;
    end
    check(name, cnt, 0);
  endtask

  task automatic pulse_reset_and_check(input string name);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check({name, "_signal"}, int'(signal), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_bcd_error"}, int'(bcd_error), 0);
    check({name, "_period_start"}, int'(period_start), 0);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    load       = 1'b0;
    ten_count  = 4'd0;
    unit_count = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_signal", int'(signal), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_bcd_error", int'(bcd_error), 0);
    check("reset_period_start", int'(period_start), 0);
    reset = 1'b0;

    // Idle: nothing may move without a load.
    quiet("idle_quiet", 3000);

    // 42 from reset: five busy cycles, three windows of 42.
    busy_exp_q.push_back(8'd5);
    win_exp_q.push_back(8'd42);
    win_exp_q.push_back(8'd42);
    win_exp_q.push_back(8'd42);
    do_load(4'd4, 4'd2);
    drain("drain_42");

    // Bad digit: one-cycle error, no busy, rate unchanged.
    sync_window();
    win_exp_q.push_back(8'd42);
    win_exp_q.push_back(8'd42);
    err_exp_q.push_back(8'd1);
    do_load(4'hA, 4'd3);
    drain("drain_bad_bcd");

    // Two loads inside one window: current window keeps 42, the last setting (20) wins.
    sync_window();
    win_exp_q.push_back(8'd42);
    repeat (298) @(posedge clk);
    busy_exp_q.push_back(8'd2);
    do_load(4'd1, 4'd5);
    repeat (100) @(posedge clk);
    busy_exp_q.push_back(8'd3);
    do_load(4'd2, 4'd0);
    win_exp_q.push_back(8'd20);
    win_exp_q.push_back(8'd20);
    drain("drain_overwrite");

    // Mid-window load of 15 takes effect at the next boundary.
    sync_window();
    win_exp_q.push_back(8'd20);
    repeat (298) @(posedge clk);
    busy_exp_q.push_back(8'd2);
    do_load(4'd1, 4'd5);
    win_exp_q.push_back(8'd15);
    win_exp_q.push_back(8'd15);
    drain("drain_15");

    // Maximum rate, then zero.
    sync_window();
    win_exp_q.push_back(8'd15);
    busy_exp_q.push_back(8'd10);
    do_load(4'd9, 4'd9);
    win_exp_q.push_back(8'd99);
    win_exp_q.push_back(8'd99);
    drain("drain_99");

    sync_window();
    win_exp_q.push_back(8'd99);
    busy_exp_q.push_back(8'd1);
    do_load(4'd0, 4'd0);
    win_exp_q.push_back(8'd0);
    win_exp_q.push_back(8'd0);
    drain("drain_0");

    // Back to 42, then reset mid-window.
    sync_window();
    win_exp_q.push_back(8'd0);
    busy_exp_q.push_back(8'd5);
    do_load(4'd4, 4'd2);
    win_exp_q.push_back(8'd42);
    drain("drain_pre_reset");
    repeat (500) @(posedge clk);
    pulse_reset_and_check("rst_run");
    quiet("post_run_reset_quiet", 2500);

    // Reset in the middle of a conversion: the setting must be lost.
    do_load(4'd9, 4'd9);
    repeat (3) @(negedge clk);
    pulse_reset_and_check("rst_conv");
    quiet("post_conv_reset_quiet", 2500);

    busy_exp_q.push_back(8'd1);
    win_exp_q.push_back(8'd7);
    win_exp_q.push_back(8'd7);
    do_load(4'd0, 4'd7);
    drain("drain_7");

    repeat (20) @(negedge clk);
    check("busy_queue_empty", busy_exp_q.size(), 0);
    check("bcd_queue_empty", err_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
